// File: rtl/blob_stats_reader.sv
// Reads one thresholded frame over the bus in bursts and accumulates blob statistics for CI readback.
// Stats land one cycle after each data beat; reads are never stalled and the bus is held only until the slave ends the burst.
module blob_stats_reader #(
  parameter logic [7:0] customInstructionId = 8'd0,
  parameter int         maxBurstWords       = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ciStart,
  input  logic        ciCke,
  input  logic [7:0]  ciN,
  input  logic [31:0] ciValueA,
  input  logic [31:0] ciValueB,
  output logic [31:0] ciResult,
  output logic        ciDone,
  output logic        requestBus,
  input  logic        busGrant,
  output logic        beginTransactionOut,
  output logic [31:0] addressDataOut,
  output logic        endTransactionOut,
  output logic [3:0]  byteEnablesOut,
  output logic [7:0]  burstSizeOut,
  output logic        dataValidOut,
  input  logic [31:0] addressDataIn,
  input  logic        dataValidIn,
  input  logic        endTransactionIn,
  input  logic        busErrorIn,
  input  logic        busyIn
);

  typedef enum logic [2:0] {IDLE, REQUEST, INIT, RECEIVE, ABORT, FLUSH} stateT;

  localparam logic [20:0] MAX_BURST   = 21'(maxBurstWords);
  localparam logic [8:0]  MAX_BURST_9 = 9'(maxBurstWords);

  stateT       state;
  logic [31:0] baseReg;
  logic [10:0] widthReg;
  logic [10:0] heightReg;
  logic        busyReg;
  logic        doneReg;
  logic        errorReg;
  logic [19:0] countReg;
  logic [31:0] sumX;
  logic [31:0] sumY;
  logic [15:0] minX;
  logic [15:0] minY;
  logic [15:0] maxX;
  logic [15:0] maxY;
  logic [31:0] addrReg;
  logic [20:0] remaining;
  logic [15:0] xPos;
  logic [15:0] yPos;
  logic        pipeVld;
  logic [31:0] pipeWord;
  logic [15:0] pipeX;
  logic [15:0] pipeY;

  logic [3:0]  cmd;
  logic [20:0] frameWords;
  logic [8:0]  burstWords;
  logic [20:0] remNext;
  logic        lowSet;
  logic        highSet;
  logic [1:0]  setCount;
  logic [15:0] pipeX1;
  logic [31:0] xAdd;
  logic [31:0] yAdd;
  logic [15:0] candMinX;
  logic [15:0] candMaxX;
  logic        unusedInputs;

  assign unusedInputs = ^{busyIn, ciValueA[31:4], ciValueB[1:0]};

  assign cmd          = ciValueA[3:0];
  assign ciDone       = ciStart & ciCke & (ciN == customInstructionId);
  assign dataValidOut = 1'b0;
  assign frameWords   = {11'd0, widthReg[10:1]} * {10'd0, heightReg};
  assign burstWords   = (remaining > MAX_BURST) ? MAX_BURST_9 : remaining[8:0];
  assign remNext      = remaining - {20'd0, dataValidIn};

  // Low halfword is pixel x, high halfword is pixel x+1.
  assign lowSet   = |pipeWord[15:0];
  assign highSet  = |pipeWord[31:16];
  assign setCount = {1'b0, lowSet} + {1'b0, highSet};
  assign pipeX1   = pipeX + 16'd1;
  assign xAdd     = (lowSet ? {16'd0, pipeX} : 32'd0) + (highSet ? {16'd0, pipeX1} : 32'd0);
  assign yAdd     = (setCount == 2'd2) ? {15'd0, pipeY, 1'b0} :
                    (setCount == 2'd1) ? {16'd0, pipeY} : 32'd0;
  assign candMinX = lowSet ? pipeX : pipeX1;
  assign candMaxX = highSet ? pipeX1 : pipeX;

  always_comb begin
    ciResult = 32'd0;
    if (ciDone) begin
      case (cmd)
        4'd3:    ciResult = {29'd0, errorReg, doneReg, busyReg};
        4'd4:    ciResult = {12'd0, countReg};
        4'd5:    ciResult = sumX;
        4'd6:    ciResult = sumY;
        4'd7:    ciResult = {minY, minX};
        4'd8:    ciResult = {maxY, maxX};
        4'd9:    ciResult = baseReg;
        default: ciResult = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= IDLE;
      requestBus          <= 1'b0;
      beginTransactionOut <= 1'b0;
      addressDataOut      <= 32'd0;
      endTransactionOut   <= 1'b0;
      byteEnablesOut      <= 4'd0;
      burstSizeOut        <= 8'd0;
      baseReg             <= 32'd0;
      widthReg            <= 11'd0;
      heightReg           <= 11'd0;
      busyReg             <= 1'b0;
      doneReg             <= 1'b0;
      errorReg            <= 1'b0;
      countReg            <= 20'd0;
      sumX                <= 32'd0;
      sumY                <= 32'd0;
      minX                <= 16'hFFFF;
      minY                <= 16'hFFFF;
      maxX                <= 16'd0;
      maxY                <= 16'd0;
      addrReg             <= 32'd0;
      remaining           <= 21'd0;
      xPos                <= 16'd0;
      yPos                <= 16'd0;
      pipeVld             <= 1'b0;
      pipeWord            <= 32'd0;
      pipeX               <= 16'd0;
      pipeY               <= 16'd0;
    end else begin
      beginTransactionOut <= 1'b0;
      addressDataOut      <= 32'd0;
      endTransactionOut   <= 1'b0;
      byteEnablesOut      <= 4'd0;
      burstSizeOut        <= 8'd0;
      pipeVld             <= (state == RECEIVE) && dataValidIn && !busErrorIn;

      if (pipeVld) begin
        countReg <= countReg + {18'd0, setCount};
        sumX     <= sumX + xAdd;
        sumY     <= sumY + yAdd;
        if (lowSet || highSet) begin
          if (candMinX < minX) minX <= candMinX;
          if (candMaxX > maxX) maxX <= candMaxX;
          if (pipeY < minY)    minY <= pipeY;
          if (pipeY > maxY)    maxY <= pipeY;
        end
      end

      case (state)
        REQUEST: begin
          if (busGrant) begin
            requestBus <= 1'b0;
            state      <= INIT;
          end
        end
        INIT: begin
          beginTransactionOut <= 1'b1;
          addressDataOut      <= addrReg;
          byteEnablesOut      <= 4'hF;
          burstSizeOut        <= 8'(burstWords - 9'd1);
          state               <= RECEIVE;
        end
        RECEIVE: begin
          if (busErrorIn) begin
            endTransactionOut <= 1'b1;
            state             <= ABORT;
          end else begin
            if (dataValidIn) begin
              addrReg   <= addrReg + 32'd4;
              remaining <= remNext;
              pipeWord  <= addressDataIn;
              pipeX     <= xPos;
              pipeY     <= yPos;
              if (xPos + 16'd2 == {5'd0, widthReg}) begin
                xPos <= 16'd0;
                yPos <= yPos + 16'd1;
              end else begin
                xPos <= xPos + 16'd2;
              end
            end
            if (endTransactionIn) begin
              if (remNext != 21'd0) begin
                requestBus <= 1'b1;
                state      <= REQUEST;
              end else begin
                state <= FLUSH;
              end
            end
          end
        end
        ABORT: begin
          errorReg <= 1'b1;
          busyReg  <= 1'b0;
          state    <= IDLE;
        end
        FLUSH: begin
          // Last beat's stats commit while pipeVld is high; finish once it clears.
          if (!pipeVld) begin
            busyReg <= 1'b0;
            doneReg <= 1'b1;
            state   <= IDLE;
          end
        end
        default: ;
      endcase

      if (ciDone) begin
        case (cmd)
          4'd0: baseReg <= {ciValueB[31:2], 2'b00};
          4'd1: begin
            widthReg  <= {ciValueB[10:1], 1'b0};
            heightReg <= ciValueB[26:16];
          end
          4'd2: begin
            if (!busyReg) begin
              countReg  <= 20'd0;
              sumX      <= 32'd0;
              sumY      <= 32'd0;
              minX      <= 16'hFFFF;
              minY      <= 16'hFFFF;
              maxX      <= 16'd0;
              maxY      <= 16'd0;
              doneReg   <= 1'b0;
              errorReg  <= 1'b0;
              xPos      <= 16'd0;
              yPos      <= 16'd0;
              addrReg   <= baseReg;
              remaining <= frameWords;
              if (frameWords == 21'd0) begin
                doneReg <= 1'b1;
              end else begin
                busyReg    <= 1'b1;
                requestBus <= 1'b1;
                state      <= REQUEST;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_blob_stats_reader.sv
// Scoreboard bench for blob_stats_reader: a bus slave model streams frames and expected bursts/CI reads are queued at stimulus time.
module tb_blob_stats_reader;

  logic        clock = 1'b0;
  logic        reset;
  logic        ciStart, ciCke;
  logic [7:0]  ciN;
  logic [31:0] ciValueA, ciValueB, ciResult;
  logic        ciDone;
  logic        requestBus, busGrant, beginTransactionOut, endTransactionOut;
  logic [31:0] addressDataOut, addressDataIn;
  logic [3:0]  byteEnablesOut;
  logic [7:0]  burstSizeOut;
  logic        dataValidOut, dataValidIn, endTransactionIn, busErrorIn, busyIn;

  always #5 clock = ~clock;

  blob_stats_reader dut (
    .clock(clock), .reset(reset),
    .ciStart(ciStart), .ciCke(ciCke), .ciN(ciN), .ciValueA(ciValueA), .ciValueB(ciValueB),
    .ciResult(ciResult), .ciDone(ciDone),
    .requestBus(requestBus), .busGrant(busGrant),
    .beginTransactionOut(beginTransactionOut), .addressDataOut(addressDataOut),
    .endTransactionOut(endTransactionOut), .byteEnablesOut(byteEnablesOut),
    .burstSizeOut(burstSizeOut), .dataValidOut(dataValidOut),
    .addressDataIn(addressDataIn), .dataValidIn(dataValidIn),
    .endTransactionIn(endTransactionIn), .busErrorIn(busErrorIn), .busyIn(busyIn)
  );

  int nCompared   = 0;
  int nMismatched = 0;

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] want);
    nCompared++;
    if (got !== want) begin
      nMismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
    end
  endtask

  logic [39:0] beginQ[$];
  logic [31:0] ciQ[$];
  logic [31:0] frameMem[0:4095];
  logic [31:0] curBase = 32'd0;
  int          curW = 0, curH = 0;
  int          errWord = -1;
  int          endOutCount = 0;
  int          reqCount = 0;

  logic [31:0] expCount, expSumX, expSumY, expMin, expMax;

  // Bus slave model: grants at once, streams words from frameMem, ends burst with last beat.
  initial begin
    int          wordsLeft;
    int          idx;
    logic [31:0] rdAddr;
    logic [39:0] exp;
    wordsLeft = 0;
    rdAddr    = 32'd0;
    forever begin
      @(negedge clock);
      busGrant = 1'b0; dataValidIn = 1'b0; endTransactionIn = 1'b0;
      busErrorIn = 1'b0; addressDataIn = 32'd0;
      if (endTransactionOut) endOutCount++;
      if (requestBus) begin
        reqCount++;
        busGrant = 1'b1;
      end
      if (reset) begin
        wordsLeft = 0;
      end else if (beginTransactionOut) begin
        exp = (beginQ.size() != 0) ? beginQ.pop_front() : 40'hFF_FFFF_FFFF;
        checkValue("beginAddr", addressDataOut, exp[39:8]);
        checkValue("burstSize", {24'd0, burstSizeOut}, {24'd0, exp[7:0]});
        checkValue("byteEnables", {28'd0, byteEnablesOut}, 32'h0000000F);
        wordsLeft = int'(burstSizeOut) + 1;
        rdAddr    = addressDataOut;
      end else if (wordsLeft > 0) begin
        idx = int'((rdAddr - curBase) >> 2) & 4095;
        if (idx == errWord) begin
          busErrorIn = 1'b1;
          wordsLeft  = 0;
        end else begin
          dataValidIn      = 1'b1;
          addressDataIn    = frameMem[idx];
          endTransactionIn = (wordsLeft == 1);
          wordsLeft--;
          rdAddr += 32'd4;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exhausted, required summary before 500000");
    $fatal(1, "watchdog");
  end

  task automatic ciRaw(input logic [3:0] cmd, input logic [31:0] valB, output logic [31:0] res);
    @(negedge clock);
    ciStart = 1'b1; ciCke = 1'b1; ciN = 8'd0;
    ciValueA = {28'd0, cmd}; ciValueB = valB;
    #1 res = ciResult;
    @(posedge clock);
    #1 ciStart = 1'b0; ciCke = 1'b0; ciValueA = 32'd0; ciValueB = 32'd0;
  endtask

  task automatic ciRead(input string tag, input logic [3:0] cmd, input logic [31:0] want);
    logic [31:0] got;
    ciQ.push_back(want);
    ciRaw(cmd, 32'd0, got);
    checkValue(tag, got, ciQ.pop_front());
  endtask

  task automatic setupFrame(input logic [31:0] base, input int w, input int h);
    logic [31:0] dummy;
    curBase = base; curW = w; curH = h;
    ciRaw(4'd0, base, dummy);
    ciRaw(4'd1, (32'(h) << 16) | 32'(w), dummy);
  endtask

  // Reference statistics straight from the frame contents and geometry.
  task automatic computeModel();
    int perRow, words, row, x, cnt, sx, sy, mnx, mny, mxx, mxy;
    perRow = (curW & ~1) / 2;
    words  = perRow * curH;
    cnt = 0; sx = 0; sy = 0; mnx = 'hFFFF; mny = 'hFFFF; mxx = 0; mxy = 0;
    for (int i = 0; i < words; i++) begin
      row = i / perRow;
      x   = 2 * (i % perRow);
      for (int h = 0; h < 2; h++) begin
        if ((h == 0 && frameMem[i][15:0] != 16'd0) || (h == 1 && frameMem[i][31:16] != 16'd0)) begin
          cnt++; sx += x + h; sy += row;
          if (x + h < mnx) mnx = x + h;
          if (x + h > mxx) mxx = x + h;
          if (row < mny) mny = row;
          if (row > mxy) mxy = row;
        end
      end
    end
    expCount = 32'(cnt); expSumX = 32'(sx); expSumY = 32'(sy);
    expMin = {16'(mny), 16'(mnx)};
    expMax = {16'(mxy), 16'(mxx)};
  endtask

  task automatic pushBegins(input int maxPush);
    int          rem, b, n;
    logic [31:0] a;
    rem = ((curW & ~1) / 2) * curH;
    a = curBase; n = 0;
    while (rem > 0 && n < maxPush) begin
      b = (rem > 16) ? 16 : rem;
      beginQ.push_back({a, 8'(b - 1)});
      a += 32'(4 * b); rem -= b; n++;
    end
  endtask

  task automatic startFrame();
    logic [31:0] dummy;
    ciRaw(4'd2, 32'd0, dummy);
  endtask

  task automatic waitDone(input logic [31:0] expStatus, input int budget);
    logic [31:0] st;
    int n;
    n = 0;
    do begin
      ciRaw(4'd3, 32'd0, st);
      n++;
    end while ((st[0] || !(st[1] || st[2])) && n < budget);
    if (n >= budget) checkValue("waitTimeout", st, expStatus);
  endtask

  task automatic checkStats(input string tag);
    computeModel();
    ciRead({tag, ".count"}, 4'd4, expCount);
    ciRead({tag, ".sumX"},  4'd5, expSumX);
    ciRead({tag, ".sumY"},  4'd6, expSumY);
    ciRead({tag, ".min"},   4'd7, expMin);
    ciRead({tag, ".max"},   4'd8, expMax);
  endtask

  task automatic fillRandom(input int words);
    for (int i = 0; i < words; i++) begin
      frameMem[i][15:0]  = ($urandom_range(0, 1) == 1) ? 16'($urandom) | 16'd1 : 16'd0;
      frameMem[i][31:16] = ($urandom_range(0, 1) == 1) ? 16'($urandom) | 16'd1 : 16'd0;
    end
  endtask

  task automatic runSmallFrame(input string tag);
    frameMem[0] = 32'h0000FFFF; frameMem[1] = 32'h0;
    frameMem[2] = 32'hFFFF0000; frameMem[3] = 32'h00010001;
    setupFrame(32'h1000, 4, 2);
    pushBegins(1000);
    startFrame();
    waitDone(32'd2, 200);
    ciRead({tag, ".status"}, 4'd3, 32'd2);
    checkStats(tag);
    ciRead({tag, ".base"}, 4'd9, 32'h1000);
  endtask

  initial begin
    int          endBefore, reqBefore;
    logic        sawBegin;
    logic [31:0] got;
    reset = 1'b1; ciStart = 1'b0; ciCke = 1'b0; ciN = 8'd0;
    ciValueA = 32'd0; ciValueB = 32'd0; busyIn = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    checkValue("rst.requestBus", {31'd0, requestBus}, 32'd0);
    checkValue("rst.begin", {31'd0, beginTransactionOut}, 32'd0);
    checkValue("rst.address", addressDataOut, 32'd0);
    checkValue("rst.burstSize", {24'd0, burstSizeOut}, 32'd0);
    checkValue("rst.dataValidOut", {31'd0, dataValidOut}, 32'd0);
    ciRead("rst.status", 4'd3, 32'd0);
    ciRead("rst.count", 4'd4, 32'd0);
    ciRead("rst.min", 4'd7, 32'hFFFFFFFF);
    ciRead("rst.max", 4'd8, 32'd0);
    ciRead("rst.base", 4'd9, 32'd0);

    // Foreign opcode must neither complete nor drive data.
    @(negedge clock);
    ciStart = 1'b1; ciCke = 1'b1; ciN = 8'h05; ciValueA = 32'd9;
    #1 checkValue("otherOpcode.done", {31'd0, ciDone}, 32'd0);
    checkValue("otherOpcode.result", ciResult, 32'd0);
    @(posedge clock);
    #1 ciStart = 1'b0; ciCke = 1'b0; ciN = 8'd0; ciValueA = 32'd0;

    runSmallFrame("small");

    // Two bursts, busy readback and an ignored restart mid-frame.
    fillRandom(20);
    setupFrame(32'h2000, 40, 1);
    pushBegins(1000);
    startFrame();
    repeat (6) @(negedge clock);
    ciRead("w40.statusBusy", 4'd3, 32'd1);
    startFrame();
    waitDone(32'd2, 200);
    ciRead("w40.status", 4'd3, 32'd2);
    checkStats("w40");
    checkValue("w40.beginsLeft", 32'(beginQ.size()), 32'd0);

    // All-zero frame: 80 full bursts.
    for (int i = 0; i < 1280; i++) frameMem[i] = 32'd0;
    setupFrame(32'h10000, 64, 40);
    pushBegins(1000);
    startFrame();
    waitDone(32'd2, 4000);
    ciRead("zero.status", 4'd3, 32'd2);
    checkStats("zero");
    checkValue("zero.beginsLeft", 32'(beginQ.size()), 32'd0);

    // Bus error on the 5th word, then a clean rerun.
    fillRandom(20);
    setupFrame(32'h3000, 40, 1);
    errWord = 4;
    pushBegins(1);
    endBefore = endOutCount;
    startFrame();
    waitDone(32'd4, 200);
    ciRead("err.status", 4'd3, 32'd4);
    checkValue("err.endPulses", 32'(endOutCount - endBefore), 32'd1);
    checkValue("err.beginsLeft", 32'(beginQ.size()), 32'd0);
    errWord = -1;
    pushBegins(1000);
    startFrame();
    waitDone(32'd2, 200);
    ciRead("rerun.status", 4'd3, 32'd2);
    checkStats("rerun");

    // Zero-height frame completes without touching the bus.
    setupFrame(32'h4000, 4, 0);
    reqBefore = reqCount;
    startFrame();
    ciRead("h0.status", 4'd3, 32'd2);
    repeat (5) @(negedge clock);
    checkValue("h0.requests", 32'(reqCount - reqBefore), 32'd0);

    // Reset in the middle of a burst.
    fillRandom(20);
    setupFrame(32'h5000, 40, 1);
    pushBegins(1000);
    startFrame();
    sawBegin = 1'b0;
    for (int n = 0; n < 50 && !sawBegin; n++) begin
      @(negedge clock);
      sawBegin = beginTransactionOut;
    end
    checkValue("midRst.beginSeen", {31'd0, sawBegin}, 32'd1);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkValue("midRst.requestBus", {31'd0, requestBus}, 32'd0);
    checkValue("midRst.begin", {31'd0, beginTransactionOut}, 32'd0);
    checkValue("midRst.address", addressDataOut, 32'd0);
    checkValue("midRst.endOut", {31'd0, endTransactionOut}, 32'd0);
    checkValue("midRst.byteEnables", {28'd0, byteEnablesOut}, 32'd0);
    ciRead("midRst.status", 4'd3, 32'd0);
    ciRead("midRst.count", 4'd4, 32'd0);
    beginQ.delete();
    @(negedge clock);
    reset = 1'b0;
    ciRead("midRst.base", 4'd9, 32'd0);
    repeat (5) @(negedge clock);
    checkValue("midRst.idle", {31'd0, requestBus}, 32'd0);
    runSmallFrame("afterRst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
